ro_scan_controller: RTL and testbench
=====================================

// Module: ro_scan_controller
// PURPOSE
//  Sequences the ring-oscillator bank and 16:1 output mux in the user project: steps mux select over a channel range.
//  Enables the oscillators and counts rising edges of the muxed RO output over a programmable gate window per channel.
//  Stores one count per channel in an internal 16-entry result table, read back via a registered read port (LA/WB glue).
// PARAMETERS
//  CNT_W          16  width of per-channel edge counter / result entry
//  GATE_W         16  width of gate_cycles (gate window length in clk cycles)
//  SETTLE_CYCLES  8   cycles after a select change before counting starts (mux settle + sync flush), >=3
//  SYNC_STAGES    2   flip-flops in ro_clk synchroniser, >=2
// PORTS
//  wb_clk_i     in   1       system clock
//  wb_rst_n     in   1       synchronous active-low reset
//  scan_go      in   1       1-cycle pulse: start a scan (ignored while busy)
//  first_ch     in   4       first channel of scan, sampled on accepted scan_go
//  last_ch      in   4       last channel of scan, sampled on accepted scan_go
//  gate_cycles  in   GATE_W  count window per channel, sampled on accepted scan_go
//  ro_clk       in   1       muxed RO output (asynchronous to wb_clk_i)
//  ro_sel       out  4       mux select to 16:1 mux
//  ro_en        out  1       oscillator start/enable to RO bank
//  busy         out  1       scan in progress
//  done         out  1       sticky: last scan completed; cleared on next accepted scan_go
//  rd_addr      in   4       result table read address
//  rd_data      out  CNT_W   result for rd_addr, 1-cycle latency
//  rd_ovf       out  1       overflow flag for rd_addr entry, 1-cycle latency
// BEHAVIOUR
//  Reset (wb_rst_n=0 at posedge): state=IDLE, ro_sel=0, ro_en=0, busy=0, done=0, rd_data=0, rd_ovf=0.
//   All table entries and ovf flags cleared; sync chain cleared. Reset mid-scan aborts immediately, no partial store.
//  FSM: IDLE -> SETTLE -> COUNT -> STORE -> (SETTLE | IDLE).
//   IDLE: scan_go=1 -> latch first/last/gate, ro_sel<=first_ch, ro_en<=1, busy<=1, done<=0, go SETTLE.
//   SETTLE: hold SETTLE_CYCLES cycles, counter held at 0, edges ignored; then COUNT.
//   COUNT: exactly G cycles, G = gate_cycles latched (0 treated as 1); count each synchronised rising edge.
//   STORE: 1 cycle; write count and ovf to table[ro_sel].
//    If ro_sel==last: ro_en<=0, busy<=0, done<=1, -> IDLE.
//    Else ro_sel<=ro_sel+1 (mod 16), -> SETTLE.
//  Range: first<=last scans first..last; first>last wraps (e.g. 14,15,0,1); first==last scans one channel.
//  Channels outside the range keep previous table contents.
//  Edge detect: ro_clk through SYNC_STAGES flops, plus one history flop; rise = sync & ~hist.
//   Max countable rate = wb_clk_i/2; faster inputs alias (documented, not flagged).
//  Counter saturates at 2^CNT_W-1; any further edge sets ovf for that channel; never wraps.
//  Per-channel latency: SETTLE_CYCLES + G + 1 cycles.
//   Scan of N channels: busy high N*(SETTLE_CYCLES+G+1) cycles after the go cycle.
//  scan_go while busy: ignored, no state change. done and busy never both 1.
//  Read port: rd_data/rd_ovf <= table[rd_addr] every cycle, independent of FSM.
//   Same-cycle read of entry being written in STORE returns old value.
//  ro_sel holds its last value in IDLE; ro_en is 1 only while busy.
// TESTING
//  1 Reset mid-COUNT (ch 3, first=0,last=5) -> next cycle ro_en=0,busy=0,done=0,ro_sel=0; all rd_data=0.
//  2 first=2,last=4,gate=64, SETTLE=8, ro_clk period 8 clk -> ro_sel 2,3,4; each entry 8+/-1.
//    busy high 219 cycles, done=1; entries 0,1,5..15 stay 0.
//  3 Wrap: first=14,last=1,gate=16, ro_clk period 4 -> visits 14,15,0,1; entries 4+/-1; ro_sel=1 in IDLE.
//  4 CNT_W=4, gate=100, ro_clk period 2 -> rd_data=15, rd_ovf=1 for that channel.
//    A later scan with slow ro_clk clears ovf.
//  5 gate=0, ro_clk idle -> COUNT lasts 1 cycle, entry=0, ovf=0; scan_go pulsed during busy is ignored.
//  6 Read during STORE of ch 7 at rd_addr=7 -> old value next cycle, new value the cycle after.

Source files
------------

// File: rtl/ro_scan_controller.sv
// rtl/ro_scan_controller.sv - ring-oscillator bank scan sequencer with per-channel edge counter and result table
module ro_scan_controller #(
  parameter int CNT_W         = 16,
  parameter int GATE_W        = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              scan_go,
  input  logic [3:0]        first_ch,
  input  logic [3:0]        last_ch,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              ro_clk,
  output logic [3:0]        ro_sel,
  output logic              ro_en,
  output logic              busy,
  output logic              done,
  input  logic [3:0]        rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_STORE
  } state_t;

  // The settle countdown shares the gate timer, so SETTLE_CYCLES must fit in GATE_W bits.
  localparam logic [GATE_W-1:0] SETTLE_END = GATE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [3:0]          last_q, last_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [GATE_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic [GATE_W-1:0]      gate_end;

  logic [CNT_W-1:0]    tbl_q [16];
  logic                ovf_tbl_q [16];
  logic [CNT_W-1:0]    rd_data_q;
  logic                rd_ovf_q;

  assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
  // A zero gate length behaves as a one-cycle window.
  assign gate_end = (gate_q == '0) ? '0 : (gate_q - GATE_W'(1));

  // Synchronise the asynchronous RO output and keep one history bit for rising-edge detection.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_clk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Scan sequencer state and working registers.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= '0;
      gate_q  <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gate_q  <= gate_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: settle after each select change, count over the gate window, store, advance.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gate_d  = gate_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_go) begin
          last_d  = last_ch;
          gate_d  = gate_cycles;
          sel_d   = first_ch;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          timer_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        if (timer_q == SETTLE_END) begin
          timer_d = '0;
          state_d = ST_COUNT;
        end else begin
          timer_d = timer_q + GATE_W'(1);
        end
      end
      ST_COUNT: begin
        if (rise) begin
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (timer_q == gate_end) begin
          timer_d = '0;
          state_d = ST_STORE;
        end else begin
          timer_d = timer_q + GATE_W'(1);
        end
      end
      ST_STORE: begin
        timer_d = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        if (sel_q == last_q) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          sel_d   = sel_q + 4'd1;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result table write in STORE and registered read; the read sees the pre-write contents.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < 16; i++) begin
        tbl_q[i]     <= '0;
        ovf_tbl_q[i] <= 1'b0;
      end
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      if (state_q == ST_STORE) begin
        tbl_q[sel_q]     <= cnt_q;
        ovf_tbl_q[sel_q] <= ovf_q;
      end
      rd_data_q <= tbl_q[rd_addr];
      rd_ovf_q  <= ovf_tbl_q[rd_addr];
    end
  end

  assign ro_sel  = sel_q;
  assign ro_en   = en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_data = rd_data_q;
  assign rd_ovf  = rd_ovf_q;

endmodule

// File: tb/tb_ro_scan_controller.sv
// tb/tb_ro_scan_controller.sv - randomized self-checking bench for ro_scan_controller
module tb_ro_scan_controller;

  localparam int CNT_W  = 4;
  localparam int GATE_W = 16;
  localparam int SETTLE = 8;
  localparam int SYNC   = 2;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_n;
  logic              scan_go;
  logic [3:0]        first_ch;
  logic [3:0]        last_ch;
  logic [GATE_W-1:0] gate_cycles;
  logic              ro_clk;
  logic [3:0]        ro_sel;
  logic              ro_en;
  logic              busy;
  logic              done;
  logic [3:0]        rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  int exp_cnt [16];
  bit exp_ovf [16];

  int ro_period = 0;
  int ro_ph     = 0;

  ro_scan_controller #(
    .CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .scan_go(scan_go),
    .first_ch(first_ch), .last_ch(last_ch), .gate_cycles(gate_cycles),
    .ro_clk(ro_clk), .ro_sel(ro_sel), .ro_en(ro_en), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ovf(rd_ovf)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Periodic RO stand-in: one rising edge every ro_period clk cycles, idle low when ro_period < 2.
  always @(negedge wb_clk_i) begin
    if (ro_period < 2) begin
      ro_clk = 1'b0;
      ro_ph  = 0;
    end else begin
      ro_ph  = (ro_ph + 1 >= ro_period) ? 0 : ro_ph + 1;
      ro_clk = (ro_ph < ro_period / 2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic verify_table();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(negedge wb_clk_i);
      check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(exp_cnt[a]));
      check($sformatf("rd_ovf[%0d]", a), 32'(rd_ovf), 32'(exp_ovf[a]));
    end
  endtask

  // Gate lengths are always a multiple of the RO period (or the RO is idle),
  // so any window position holds exactly gate/period rising edges.
  task automatic run_scan(input int f, input int l, input int g, input int p, input bit poke);
    int geff;
    int chs[$];
    int seen[$];
    int ch;
    int n;
    int limit;
    int edges;
    bit both_hi;
    bit en_bad;
    geff = (g == 0) ? 1 : g;
    ch = f;
    chs.push_back(ch);
    while (ch != l) begin
      ch = (ch + 1) % 16;
      chs.push_back(ch);
    end
    ro_period = p;
    repeat (4) @(negedge wb_clk_i);
    first_ch    = 4'(f);
    last_ch     = 4'(l);
    gate_cycles = GATE_W'(g);
    scan_go     = 1'b1;
    @(negedge wb_clk_i);
    scan_go = 1'b0;
    n       = 0;
    both_hi = 1'b0;
    en_bad  = 1'b0;
    limit   = chs.size() * (SETTLE + geff + 1) + 40;
    while (busy && n < limit) begin
      n++;
      if (done) both_hi = 1'b1;
      if (ro_en !== 1'b1) en_bad = 1'b1;
      if (seen.size() == 0 || seen[$] != int'(ro_sel)) seen.push_back(int'(ro_sel));
      if (poke && n == 5) begin
        scan_go     = 1'b1;
        first_ch    = 4'((f + 5) % 16);
        last_ch     = 4'((f + 9) % 16);
        gate_cycles = GATE_W'(3);
      end else begin
        scan_go = 1'b0;
      end
      @(negedge wb_clk_i);
    end
    scan_go = 1'b0;
    check("busy_len", 32'(n), 32'(chs.size() * (SETTLE + geff + 1)));
    check("done_end", 32'(done), 32'd1);
    check("ro_en_end", 32'(ro_en), 32'd0);
    check("ro_sel_idle", 32'(ro_sel), 32'(l));
    check("busy_done_excl", 32'(both_hi), 32'd0);
    check("ro_en_busy", 32'(en_bad), 32'd0);
    check("sel_visits", 32'(seen.size()), 32'(chs.size()));
    for (int i = 0; i < chs.size() && i < seen.size(); i++)
      check($sformatf("sel_seq[%0d]", i), 32'(seen[i]), 32'(chs[i]));
    edges = (p >= 2) ? geff / p : 0;
    foreach (chs[i]) begin
      exp_cnt[chs[i]] = (edges > SAT) ? SAT : edges;
      exp_ovf[chs[i]] = (edges > SAT);
    end
  endtask

  initial begin
    int wait_n;
    int old7;
    int f, l, p, m;
    wb_rst_n    = 1'b0;
    scan_go     = 1'b0;
    first_ch    = '0;
    last_ch     = '0;
    gate_cycles = '0;
    rd_addr     = '0;
    for (int i = 0; i < 16; i++) begin
      exp_cnt[i] = 0;
      exp_ovf[i] = 1'b0;
    end
    repeat (3) @(negedge wb_clk_i);
    check("rst_ro_sel", 32'(ro_sel), 32'd0);
    check("rst_ro_en", 32'(ro_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_ovf", 32'(rd_ovf), 32'd0);
    wb_rst_n = 1'b1;
    @(negedge wb_clk_i);

    run_scan(2, 4, 64, 8, 1'b0);
    verify_table();

    run_scan(14, 1, 16, 4, 1'b0);
    verify_table();

    // Reset in the middle of counting channel 3 of a 0..5 scan.
    ro_period = 4;
    repeat (4) @(negedge wb_clk_i);
    first_ch    = 4'd0;
    last_ch     = 4'd5;
    gate_cycles = GATE_W'(16);
    scan_go     = 1'b1;
    @(negedge wb_clk_i);
    scan_go = 1'b0;
    wait_n  = 0;
    while (ro_sel != 4'd3 && wait_n < 2000) begin
      wait_n++;
      @(negedge wb_clk_i);
    end
    check("reach_ch3", 32'(ro_sel == 4'd3), 32'd1);
    repeat (SETTLE + 4) @(negedge wb_clk_i);
    wb_rst_n = 1'b0;
    @(negedge wb_clk_i);
    check("midrst_ro_en", 32'(ro_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ro_sel", 32'(ro_sel), 32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'd0);
    wb_rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_cnt[i] = 0;
      exp_ovf[i] = 1'b0;
    end
    verify_table();

    run_scan(9, 9, 100, 2, 1'b0);
    verify_table();
    run_scan(9, 9, 32, 8, 1'b0);
    verify_table();

    run_scan(5, 6, 0, 0, 1'b1);
    verify_table();

    run_scan(7, 7, 24, 4, 1'b0);
    rd_addr = 4'd7;
    old7    = exp_cnt[7];
    run_scan(7, 7, 40, 4, 1'b0);
    check("store_read_old", 32'(rd_data), 32'(old7));
    @(negedge wb_clk_i);
    check("store_read_new", 32'(rd_data), 32'(exp_cnt[7]));

    for (int it = 0; it < 6; it++) begin
      f = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 15));
      m = int'($urandom_range(0, 12));
      p = (m == 0) ? 0 : int'($urandom_range(2, 6));
      run_scan(f, l, p * m, p, it[0]);
      verify_table();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
